// File: rtl/conv_data_feeder_if.sv
// Handshake bundle between the upstream producer, the conv_data_feeder and the
// downstream conv layer. Signal suffixes are written from the feeder's view.
interface conv_data_feeder_if #(
  parameter int WORD_SIZE = 16
);
  // Upstream word stream (valid/ready).
  logic                        valid_i;
  logic                        ready_o;
  logic signed [WORD_SIZE-1:0] data_i;

  // Downstream conv layer: frame start pulse plus valid/yumi word stream.
  logic                        conv_ready_i;
  logic                        start_o;
  logic                        valid_o;
  logic                        yumi_i;
  logic signed [WORD_SIZE-1:0] data_o;

  // The feeder itself.
  modport slave (
    input  valid_i, data_i, conv_ready_i, yumi_i,
    output ready_o, start_o, valid_o, data_o
  );

  // The environment around the feeder (producer + conv layer).
  modport master (
    output valid_i, data_i, conv_ready_i, yumi_i,
    input  ready_o, start_o, valid_o, data_o
  );
endinterface

// File: rtl/conv_data_feeder.sv
// Ping-pong frame buffer between a word-serial producer and a conv layer.
// The write side fills one bank while the read side streams the other; a
// completed bank is announced with a one-cycle start pulse and then streamed
// word by word under the conv layer's yumi handshake.
module conv_data_feeder #(
  parameter int INPUT_LAYER_HEIGHT = 64,
  parameter int KERNEL_WIDTH       = 2,
  parameter int WORD_SIZE          = 16
) (
  input logic               clk_i,
  input logic               reset_i,
  conv_data_feeder_if.slave bus
);

  localparam int FRAME_SIZE = KERNEL_WIDTH * INPUT_LAYER_HEIGHT;
  localparam int AW         = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {
    eIDLE,
    eSTART,
    eSTREAM
  } state_e;

  // Frame storage: two banks of FRAME_SIZE words.
  logic signed [WORD_SIZE-1:0] mem_q [2][FRAME_SIZE];

  // Write-side state.
  logic [1:0]    full_q,    full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;

  // Read-side state.
  state_e        state_q;
  logic          rd_bank_q;
  logic [AW-1:0] rd_addr_q;
  logic          start_q;
  logic          valid_q;

  logic wr_fire;
  logic rd_fire;
  logic rd_last;

  assign bus.ready_o = ~full_q[wr_bank_q];
  assign wr_fire     = bus.valid_i & bus.ready_o;

  // A yumi only counts while a word is actually being presented.
  assign rd_fire = valid_q & bus.yumi_i;
  assign rd_last = rd_fire & (rd_addr_q == LAST_ADDR);

  assign bus.start_o = start_q;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = valid_q ? mem_q[rd_bank_q][rd_addr_q] : '0;

  // Next-state for the write pointer and the shared full flags; the write side
  // can only complete a non-full bank and the read side can only release a
  // full one, so both updates land on different banks when they coincide.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    if (wr_fire) begin
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_d         = '0;
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  // Write pointer and full flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset_i) begin
      wr_addr_q <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      wr_addr_q <= wr_addr_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
    end
  end

  // Bank storage write port.
  // NOTE: the banks carry no reset; the full flags alone decide what is valid,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_addr_q] <= bus.data_i;
    end
  end

  // Read FSM: wait for a full bank and an idle conv layer, pulse start, then
  // stream the bank and release it after its last word is consumed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= eIDLE;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        eIDLE: begin
          if (full_q[rd_bank_q] && bus.conv_ready_i) begin
            state_q <= eSTART;
            start_q <= 1'b1;
          end
        end
        eSTART: begin
          state_q <= eSTREAM;
          start_q <= 1'b0;
          valid_q <= 1'b1;
        end
        eSTREAM: begin
          if (rd_fire) begin
            if (rd_addr_q == LAST_ADDR) begin
              rd_addr_q <= '0;
              rd_bank_q <= ~rd_bank_q;
              valid_q   <= 1'b0;
              state_q   <= eIDLE;
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= eIDLE;
          start_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_data_feeder.sv
// Self-checking bench for conv_data_feeder with FRAME_SIZE = 4. A scoreboard
// queue receives every word the DUT accepts and is popped on every consumed
// word, so stream order and content are checked throughout every scenario.
module tb_conv_data_feeder;

  localparam int WS = 16;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  conv_data_feeder_if #(.WORD_SIZE(WS)) bus ();

  conv_data_feeder #(
    .INPUT_LAYER_HEIGHT(2),
    .KERNEL_WIDTH      (2),
    .WORD_SIZE         (WS)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;
  int start_cnt    = 0;
  bit pushed;
  bit popped;
  logic signed [WS-1:0] exp_q[$];

  // One cycle: score the current outputs against the model, record any
  // accepted word, then advance to the next falling edge.
  task automatic step();
    logic signed [WS-1:0] exp_w;
    pushed = 1'b0;
    popped = 1'b0;
    if (bus.valid_o !== 1'b1) begin
      tests_run++;
      if (bus.data_o !== '0) begin
        tests_failed++;
        $display("FAIL idle_data: data_o=%0d, expected 0", bus.data_o);
      end
    end else if (bus.yumi_i) begin
      tests_run++;
      popped = 1'b1;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_underflow: data_o=%0d streamed, no word expected", bus.data_o);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.data_o !== exp_w) begin
          tests_failed++;
          $display("FAIL sb_data: data_o=%0d, expected %0d", bus.data_o, exp_w);
        end
      end
    end
    if (bus.valid_i && bus.ready_o) begin
      exp_q.push_back(bus.data_i);
      pushed = 1'b1;
    end
    if (bus.start_o) start_cnt++;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    bus.valid_i      = 1'b0;
    bus.data_i       = '0;
    bus.conv_ready_i = 1'b0;
    bus.yumi_i       = 1'b0;
    reset_i          = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    exp_q.delete();
  endtask

  // Offer n consecutive words starting at first; each waits (bounded) for ready.
  task automatic write_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      int cyc;
      bus.valid_i = 1'b1;
      bus.data_i  = WS'(first + i);
      cyc = 0;
      pushed = 1'b0;
      while (!pushed && cyc < 50) begin
        step();
        cyc++;
      end
      if (!pushed) begin
        tests_run++;
        tests_failed++;
        $display("FAIL write_timeout: word %0d not accepted, expected accept within 50 cycles", first + i);
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic drain_n(input int n, input int budget, input string name);
    int pops = 0;
    int cyc  = 0;
    while (pops < n && cyc < budget) begin
      step();
      if (popped) pops++;
      cyc++;
    end
    tests_run++;
    if (pops != n) begin
      tests_failed++;
      $display("FAIL %s: consumed %0d words, expected %0d", name, pops, n);
    end
  endtask

  task automatic drain_all(input int budget, input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      step();
      cyc++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s: %0d words left unstreamed, expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int cyc = 0;
    while (bus.valid_o !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
    tests_run++;
    if (bus.valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: valid_o=%0b after %0d cycles, expected 1", name, bus.valid_o, budget);
    end
  endtask

  task automatic test_reset();
    bus.valid_i      = 1'b0;
    bus.data_i       = '0;
    bus.conv_ready_i = 1'b1;
    bus.yumi_i       = 1'b1;
    reset_i          = 1'b1;
    #1;
    tests_run += 3;
    if (bus.start_o !== 1'b0) begin tests_failed++; $display("FAIL rst_start: start_o=%0b, expected 0", bus.start_o); end
    if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: valid_o=%0b, expected 0", bus.valid_o); end
    if (bus.data_o !== '0) begin tests_failed++; $display("FAIL rst_data: data_o=%0d, expected 0", bus.data_o); end
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    tests_run++;
    if (bus.ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: ready_o=%0b, expected 1", bus.ready_o); end
    @(negedge clk_i);
    // Nothing was written, so nothing may start even with conv_ready_i high.
    repeat (4) step();
    tests_run++;
    if (start_cnt != 0) begin tests_failed++; $display("FAIL rst_no_start: start pulses=%0d, expected 0", start_cnt); end
  endtask

  task automatic test_single_frame();
    apply_reset();
    bus.conv_ready_i = 1'b1;
    bus.yumi_i       = 1'b1;
    write_words(1, 4);
    tests_run++;
    if (bus.start_o !== 1'b0) begin tests_failed++; $display("FAIL sf_start_early: start_o=%0b, expected 0", bus.start_o); end
    step();
    tests_run += 2;
    if (bus.start_o !== 1'b1) begin tests_failed++; $display("FAIL sf_start: start_o=%0b, expected 1", bus.start_o); end
    if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL sf_start_valid: valid_o=%0b, expected 0", bus.valid_o); end
    step();
    for (int i = 0; i < 4; i++) begin
      tests_run += 2;
      if (bus.valid_o !== 1'b1) begin tests_failed++; $display("FAIL sf_valid: valid_o=%0b at word %0d, expected 1", bus.valid_o, i); end
      if (bus.start_o !== 1'b0) begin tests_failed++; $display("FAIL sf_start_len: start_o=%0b at word %0d, expected 0", bus.start_o, i); end
      step();
    end
    tests_run += 2;
    if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL sf_end_valid: valid_o=%0b, expected 0", bus.valid_o); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL sf_drained: %0d words left, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int s0;
    apply_reset();
    bus.yumi_i = 1'b1;
    write_words(10, 8);
    tests_run++;
    if (bus.ready_o !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_low: ready_o=%0b, expected 0", bus.ready_o); end
    bus.valid_i = 1'b1;
    bus.data_i  = WS'(99);
    repeat (3) step();
    bus.valid_i = 1'b0;
    tests_run += 2;
    if (bus.ready_o !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_hold: ready_o=%0b, expected 0", bus.ready_o); end
    if (exp_q.size() != 8) begin tests_failed++; $display("FAIL bp_no_overwrite: %0d words queued, expected 8", exp_q.size()); end
    s0 = start_cnt;
    bus.conv_ready_i = 1'b1;
    drain_n(8, 40, "bp_drain");
    tests_run += 2;
    if (start_cnt - s0 != 2) begin tests_failed++; $display("FAIL bp_starts: %0d start pulses, expected 2", start_cnt - s0); end
    if (bus.ready_o !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_back: ready_o=%0b, expected 1", bus.ready_o); end
  endtask

  task automatic test_yumi_toggle();
    apply_reset();
    bus.conv_ready_i = 1'b1;
    write_words(20, 4);
    wait_valid(10, "yt_wait_valid");
    for (int i = 0; i < 8; i++) begin
      bus.yumi_i = (i % 2 == 0);
      if (!bus.yumi_i && bus.valid_o && exp_q.size() != 0) begin
        tests_run++;
        if (bus.data_o !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL yt_hold: data_o=%0d, expected %0d", bus.data_o, exp_q[0]);
        end
      end
      step();
    end
    bus.yumi_i = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL yt_drained: %0d words left, expected 0", exp_q.size()); end
  endtask

  task automatic test_yumi_ignored();
    apply_reset();
    bus.yumi_i = 1'b1;
    write_words(30, 4);
    repeat (3) step();
    bus.conv_ready_i = 1'b1;
    wait_valid(10, "yi_wait_valid");
    tests_run++;
    if (bus.data_o !== WS'(30)) begin tests_failed++; $display("FAIL yi_first: data_o=%0d, expected 30", bus.data_o); end
    drain_all(20, "yi_drain");
  endtask

  task automatic test_full_handoff();
    apply_reset();
    write_words(40, 8);
    tests_run++;
    if (bus.ready_o !== 1'b0) begin tests_failed++; $display("FAIL fh_full: ready_o=%0b, expected 0", bus.ready_o); end
    bus.valid_i      = 1'b1;
    bus.data_i       = WS'(48);
    bus.conv_ready_i = 1'b1;
    bus.yumi_i       = 1'b1;
    drain_n(4, 20, "fh_first_frame");
    tests_run += 2;
    if (bus.ready_o !== 1'b1) begin tests_failed++; $display("FAIL fh_ready_rise: ready_o=%0b, expected 1", bus.ready_o); end
    if (exp_q.size() != 4) begin tests_failed++; $display("FAIL fh_no_early_write: %0d words queued, expected 4", exp_q.size()); end
    write_words(48, 4);
    drain_all(40, "fh_drain");
  endtask

  task automatic test_mid_reset();
    int s0;
    apply_reset();
    bus.yumi_i = 1'b1;
    write_words(60, 8);
    bus.conv_ready_i = 1'b1;
    drain_n(6, 30, "mr_partial");
    reset_i = 1'b1;
    #1;
    tests_run += 3;
    if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL mr_valid: valid_o=%0b, expected 0", bus.valid_o); end
    if (bus.data_o !== '0) begin tests_failed++; $display("FAIL mr_data: data_o=%0d, expected 0", bus.data_o); end
    if (bus.start_o !== 1'b0) begin tests_failed++; $display("FAIL mr_start: start_o=%0b, expected 0", bus.start_o); end
    exp_q.delete();
    @(negedge clk_i);
    reset_i = 1'b0;
    tests_run++;
    if (bus.ready_o !== 1'b1) begin tests_failed++; $display("FAIL mr_ready: ready_o=%0b, expected 1", bus.ready_o); end
    s0 = start_cnt;
    repeat (6) step();
    tests_run++;
    if (start_cnt != s0) begin tests_failed++; $display("FAIL mr_stale: %0d start pulses, expected 0", start_cnt - s0); end
    write_words(5, 4);
    drain_all(20, "mr_drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.valid_i      = 1'b0;
    bus.data_i       = '0;
    bus.conv_ready_i = 1'b0;
    bus.yumi_i       = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_single_frame();
    test_backpressure();
    test_yumi_toggle();
    test_yumi_ignored();
    test_full_handoff();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
